// File: rtl/uv_cost_issuer_pkg.sv
// Shared types and constants for the chroma cost issuer.
package uv_cost_issuer_pkg;
    typedef enum logic [1:0] {FILL, ISSUE, WAIT, HOLD} state_t;

    localparam int          COEF_PER_BLOCK = 16;
    localparam int          WATCHDOG_LIMIT = 32;
    localparam logic [31:0] ERR_SUM        = 32'hFFFF_FFFF;
endpackage

// File: rtl/uv_cost_issuer_if.sv
// Bundles the coefficient input, cost-unit and result handshakes of the issuer.
interface uv_cost_issuer_if #(
    parameter int BIT_WIDTH  = 16,
    parameter int BLOCK_SIZE = 8
);
    import uv_cost_issuer_pkg::*;

    logic                                           in_valid;
    logic                                           in_ready;
    logic [BIT_WIDTH*COEF_PER_BLOCK-1:0]            in_data;
    logic [BIT_WIDTH*COEF_PER_BLOCK*BLOCK_SIZE-1:0] cost_levels;
    logic                                           cost_start;
    logic [31:0]                                    cost_sum;
    logic                                           cost_done;
    logic                                           out_valid;
    logic                                           out_ready;
    logic [31:0]                                    out_sum;
    logic                                           out_err;

    modport master (
        input  in_valid, in_data, cost_sum, cost_done, out_ready,
        output in_ready, cost_levels, cost_start, out_valid, out_sum, out_err
    );

    modport slave (
        output in_valid, in_data, cost_sum, cost_done, out_ready,
        input  in_ready, cost_levels, cost_start, out_valid, out_sum, out_err
    );
endinterface

// File: rtl/uv_cost_issuer.sv
// Collects BLOCK_SIZE coefficient blocks, launches the cost unit once and holds its result.
// Optional watchdog on the cost unit reply: define UV_COST_ISSUER_WATCHDOG_EN.
module uv_cost_issuer
    import uv_cost_issuer_pkg::*;
#(
    parameter int BIT_WIDTH  = 16,
    parameter int BLOCK_SIZE = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    uv_cost_issuer_if.master  bus
);
    localparam int BLK_W = BIT_WIDTH * COEF_PER_BLOCK;
    localparam int BUF_W = BLK_W * BLOCK_SIZE;
    localparam int IDX_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BUF_W-1:0]   levels_q, levels_d;
    logic [31:0]        sum_q, sum_d;
    logic               err_q, err_d;
    logic               in_ready;
    logic               accept;
`ifdef UV_COST_ISSUER_WATCHDOG_EN
    logic [5:0]         wd_q, wd_d;
`endif

    // rst_n is active-high; the name is inherited from the surrounding system
    assign in_ready = (state_q == FILL) && !rst_n;
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        levels_d = levels_q;
        sum_d    = sum_q;
        err_d    = err_q;
`ifdef UV_COST_ISSUER_WATCHDOG_EN
        wd_d     = '0;
`endif
        case (state_q)
            FILL: begin
                if (accept) begin
                    levels_d[idx_q*BLK_W +: BLK_W] = bus.in_data;
                    if (idx_q == IDX_W'(BLOCK_SIZE - 1)) begin
                        idx_d   = '0;
                        state_d = ISSUE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                // a reply arriving on the expiry cycle still counts as a real result
                if (bus.cost_done) begin
                    sum_d   = bus.cost_sum;
                    err_d   = 1'b0;
                    state_d = HOLD;
                end
`ifdef UV_COST_ISSUER_WATCHDOG_EN
                else if (wd_q == 6'(WATCHDOG_LIMIT - 1)) begin
                    sum_d   = ERR_SUM;
                    err_d   = 1'b1;
                    state_d = HOLD;
                end else begin
                    wd_d = wd_q + 6'd1;
                end
`endif
            end
            HOLD: begin
                if (bus.out_ready) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q  <= FILL;
            idx_q    <= '0;
            levels_q <= '0;
            sum_q    <= '0;
            err_q    <= 1'b0;
`ifdef UV_COST_ISSUER_WATCHDOG_EN
            wd_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            levels_q <= levels_d;
            sum_q    <= sum_d;
            err_q    <= err_d;
`ifdef UV_COST_ISSUER_WATCHDOG_EN
            wd_q     <= wd_d;
`endif
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.cost_start  = (state_q == ISSUE) && !rst_n;
    assign bus.out_valid   = (state_q == HOLD) && !rst_n;
    assign bus.cost_levels = levels_q;
    assign bus.out_sum     = sum_q;
    assign bus.out_err     = err_q;
endmodule
